// File: rtl/bundle_decoder.sv
// -----------------------------------------------------------------------------
// bundle_decoder
//
// Decodes one VLIW bundle per accepted handshake. A bundle has NUM_ALU ALU
// slots, one multiply slot (M) and one load/store slot (LS). The decoded
// control word and an error flag are held in a single registered output
// stage that uses a valid/ready handshake. Sticky error bookkeeping records
// the first failing slot and counts illegal bundles, saturating at the top.
//
// Ports
//   clk, rst     : clock, asynchronous active-high reset
//   in_valid     : bundle present on alu_op/m_op/ls_op
//   in_ready     : decoder can take a bundle this cycle
//   alu_op       : ALU slot opcodes, slot k at [k*OPW +: OPW]
//   m_op, ls_op  : multiply and load/store slot opcodes
//   flush        : drop the held output and any bundle presented this cycle
//   err_clr      : clear err_sticky / err_slot / err_cnt
//   out_valid    : control/out_err hold a decoded bundle
//   out_ready    : downstream takes the held bundle
//   control      : ALU slot k {imm_sel, op[3:0]} at [4+5k +: 5],
//                  then M_imm_sel[3], M_en[2], L_en[1], S_en[0]
//   out_err      : held bundle contained an illegal opcode
//   err_sticky   : an illegal bundle has been accepted since the last clear
//   err_slot     : lowest failing slot of the first illegal bundle
//   err_cnt      : saturating count of accepted illegal bundles
// -----------------------------------------------------------------------------
module bundle_decoder #(
  parameter int NUM_ALU = 2,
  parameter int OPW     = 5,
  parameter int CNT_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_ALU*OPW-1:0]       alu_op,
  input  logic [OPW-1:0]               m_op,
  input  logic [OPW-1:0]               ls_op,
  input  logic                         flush,
  input  logic                         err_clr,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [5*NUM_ALU+3:0]         control,
  output logic                         out_err,
  output logic                         err_sticky,
  output logic [$clog2(NUM_ALU+2)-1:0] err_slot,
  output logic [CNT_W-1:0]             err_cnt
);

  localparam int CTRL_W = 5*NUM_ALU + 4;
  localparam int SLOT_W = $clog2(NUM_ALU + 2);
  localparam int NSLOT  = NUM_ALU + 2;

  // Opcode encodings shared across slots
  localparam logic [OPW-1:0] OP_ALU_MAX = OPW'(11);
  localparam logic [OPW-1:0] OP_NOP     = OPW'(12);
  localparam logic [OPW-1:0] OP_MUL     = OPW'(13);
  localparam logic [OPW-1:0] OP_MULI    = OPW'(14);
  localparam logic [OPW-1:0] OP_STORE   = OPW'(16);
  localparam logic [OPW-1:0] OP_LOAD    = OPW'(17);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // ---------------------------------------------------------------------------
  // Combinational decode of the presented bundle
  // ---------------------------------------------------------------------------
  logic [CTRL_W-1:0] dec_ctrl;
  logic [NSLOT-1:0]  slot_bad;
  logic              dec_err;
  logic [SLOT_W-1:0] dec_slot;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves
    // it unassigned; a missing default here would infer a latch.
    dec_ctrl = '0;
    slot_bad = '0;
    dec_slot = '0;

    for (int k = 0; k < NUM_ALU; k++) begin
      logic [OPW-1:0] op;
      op = alu_op[k*OPW +: OPW];
      if (op <= OP_ALU_MAX) begin
        dec_ctrl[4 + 5*k +: 5] = {op[3], op[3:0]};
      end else if (op != OP_NOP) begin
        slot_bad[k] = 1'b1;
      end
    end

    case (m_op)
      OP_NOP:  ;
      OP_MUL:  dec_ctrl[2]   = 1'b1;
      OP_MULI: dec_ctrl[3:2] = 2'b11;
      default: slot_bad[NUM_ALU] = 1'b1;
    endcase

    case (ls_op)
      OP_NOP:   ;
      OP_STORE: dec_ctrl[0] = 1'b1;
      OP_LOAD:  dec_ctrl[1] = 1'b1;
      default:  slot_bad[NUM_ALU+1] = 1'b1;
    endcase

    dec_err = |slot_bad;
    // An illegal bundle still flows downstream, but with no enables asserted.
    if (dec_err) begin
      dec_ctrl = '0;
    end

    // Scan from the highest index down so the lowest failing slot wins.
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (slot_bad[i]) begin
        dec_slot = SLOT_W'(i);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------------
  logic              out_valid_q, out_valid_d;
  logic [CTRL_W-1:0] control_q,   control_d;
  logic              out_err_q,   out_err_d;

  logic accept;

  assign in_ready = ~out_valid_q | out_ready | flush;
  // A bundle presented alongside flush is discarded, never decoded or counted.
  assign accept   = in_valid & in_ready & ~flush;

  always_comb begin
    out_valid_d = out_valid_q;
    control_d   = control_q;
    out_err_d   = out_err_q;

    if (flush) begin
      out_valid_d = 1'b0;
      control_d   = '0;
      out_err_d   = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      control_d   = dec_ctrl;
      out_err_d   = dec_err;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error bookkeeping
  // ---------------------------------------------------------------------------
  logic              err_sticky_q, err_sticky_d;
  logic [SLOT_W-1:0] err_slot_q,   err_slot_d;
  logic [CNT_W-1:0]  err_cnt_q,    err_cnt_d;

  logic accept_bad;
  assign accept_bad = accept & dec_err;

  always_comb begin
    err_sticky_d = err_sticky_q;
    err_slot_d   = err_slot_q;
    err_cnt_d    = err_cnt_q;

    if (err_clr) begin
      // A clear coinciding with a new illegal bundle restarts from that bundle.
      if (accept_bad) begin
        err_sticky_d = 1'b1;
        err_slot_d   = dec_slot;
        err_cnt_d    = CNT_W'(1);
      end else begin
        err_sticky_d = 1'b0;
        err_slot_d   = '0;
        err_cnt_d    = '0;
      end
    end else if (accept_bad) begin
      if (err_cnt_q != CNT_MAX) begin
        err_cnt_d = err_cnt_q + CNT_W'(1);
      end
      // Only the first illegal bundle since the last clear records its slot.
      if (!err_sticky_q) begin
        err_sticky_d = 1'b1;
        err_slot_d   = dec_slot;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      control_q    <= '0;
      out_err_q    <= 1'b0;
      err_sticky_q <= 1'b0;
      err_slot_q   <= '0;
      err_cnt_q    <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      control_q    <= control_d;
      out_err_q    <= out_err_d;
      err_sticky_q <= err_sticky_d;
      err_slot_q   <= err_slot_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign control    = control_q;
  assign out_err    = out_err_q;
  assign err_sticky = err_sticky_q;
  assign err_slot   = err_slot_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_bundle_decoder.sv
// -----------------------------------------------------------------------------
// tb_bundle_decoder
//
// Directed bench for bundle_decoder with NUM_ALU=2, OPW=5, CNT_W=2. Expected
// output bundles are pushed to a scoreboard queue when a bundle is accepted
// and compared against the held output every cycle it is valid; the error
// bookkeeping is tracked by a small reference model.
// -----------------------------------------------------------------------------
module tb_bundle_decoder;

  localparam int NUM_ALU = 2;
  localparam int OPW     = 5;
  localparam int CNT_W   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  alu_op;
  logic [4:0]  m_op;
  logic [4:0]  ls_op;
  logic        flush;
  logic        err_clr;
  logic        out_valid;
  logic        out_ready;
  logic [13:0] control;
  logic        out_err;
  logic        err_sticky;
  logic [1:0]  err_slot;
  logic [1:0]  err_cnt;

  bundle_decoder #(.NUM_ALU(NUM_ALU), .OPW(OPW), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_op     (alu_op),
    .m_op       (m_op),
    .ls_op      (ls_op),
    .flush      (flush),
    .err_clr    (err_clr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .control    (control),
    .out_err    (out_err),
    .err_sticky (err_sticky),
    .err_slot   (err_slot),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [13:0] c;
    logic        e;
  } exp_t;

  exp_t q[$];

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  logic       m_ov;
  logic       m_sticky;
  logic [1:0] m_slot;
  logic [1:0] m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Reference decode of one bundle
  function automatic void model_dec(input logic [4:0] a0, input logic [4:0] a1,
                                    input logic [4:0] m, input logic [4:0] ls,
                                    output logic [13:0] c, output logic e,
                                    output logic [1:0] s);
    logic [4:0] a [2];
    logic [3:0] bad;
    a[0] = a0;
    a[1] = a1;
    c    = '0;
    bad  = '0;
    for (int k = 0; k < 2; k++) begin
      if (a[k] < 5'd12)       c[4 + 5*k +: 5] = {a[k][3], a[k][3:0]};
      else if (a[k] != 5'd12) bad[k] = 1'b1;
    end
    if (m == 5'h0D)      c[2] = 1'b1;
    else if (m == 5'h0E) c[3:2] = 2'b11;
    else if (m != 5'h0C) bad[2] = 1'b1;
    if (ls == 5'h10)      c[0] = 1'b1;
    else if (ls == 5'h11) c[1] = 1'b1;
    else if (ls != 5'h0C) bad[3] = 1'b1;
    e = |bad;
    if (e) c = '0;
    if (bad[0])      s = 2'd0;
    else if (bad[1]) s = 2'd1;
    else if (bad[2]) s = 2'd2;
    else             s = 2'd3;
  endfunction

  task automatic set_b(input logic [4:0] a0, input logic [4:0] a1,
                       input logic [4:0] m, input logic [4:0] ls);
    alu_op = {a1, a0};
    m_op   = m;
    ls_op  = ls;
  endtask

  // One clock: check combinational/held outputs at negedge, advance the model,
  // then check registered outputs just after the rising edge.
  task automatic tick(input string tag);
    logic [13:0] c;
    logic        e;
    logic [1:0]  s;
    logic        exp_ir;
    logic        acc;
    logic        bad_acc;
    @(negedge clk);
    exp_ir = ~m_ov | out_ready | flush;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'(exp_ir));
    if (m_ov && q.size() > 0) begin
      chk({tag, "_control"}, 32'(control), 32'(q[0].c));
      chk({tag, "_out_err"}, 32'(out_err), 32'(q[0].e));
    end
    model_dec(alu_op[4:0], alu_op[9:5], m_op, ls_op, c, e, s);
    acc     = in_valid & exp_ir & ~flush;
    bad_acc = acc & e;

    if (flush) begin
      if (m_ov && q.size() > 0) void'(q.pop_front());
      m_ov = 1'b0;
    end else begin
      if (m_ov && out_ready && q.size() > 0) void'(q.pop_front());
      if (acc) q.push_back('{c: c, e: e});
      m_ov = acc | (m_ov & ~out_ready);
    end

    if (err_clr) begin
      m_sticky = bad_acc;
      m_slot   = bad_acc ? s : 2'd0;
      m_cnt    = bad_acc ? 2'd1 : 2'd0;
    end else if (bad_acc) begin
      if (m_cnt != 2'd3) m_cnt = m_cnt + 2'd1;
      if (!m_sticky) begin
        m_sticky = 1'b1;
        m_slot   = s;
      end
    end

    @(posedge clk);
    #1;
    chk({tag, "_out_valid"}, 32'(out_valid), 32'(m_ov));
    chk({tag, "_err_sticky"}, 32'(err_sticky), 32'(m_sticky));
    chk({tag, "_err_slot"}, 32'(err_slot), 32'(m_slot));
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(m_cnt));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_control"}, 32'(control), 32'd0);
    chk({tag, "_out_err"}, 32'(out_err), 32'd0);
    chk({tag, "_err_sticky"}, 32'(err_sticky), 32'd0);
    chk({tag, "_err_slot"}, 32'(err_slot), 32'd0);
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
  endtask

  task automatic model_reset();
    q.delete();
    m_ov     = 1'b0;
    m_sticky = 1'b0;
    m_slot   = 2'd0;
    m_cnt    = 2'd0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    flush     = 1'b0;
    err_clr   = 1'b0;
    out_ready = 1'b1;
    set_b(5'h0C, 5'h0C, 5'h0C, 5'h0C);
    model_reset();

    // Reset state
    #12;
    chk_all_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // Reference bundle: slot1 {1,9}, slot0 {0,3}, MULI, load
    in_valid = 1'b1;
    set_b(5'h03, 5'h09, 5'h0E, 5'h11);
    tick("ref_bundle");
    chk("ref_bundle_literal", 32'(control), 32'h323E);
    in_valid = 1'b0;
    tick("ref_drain");

    // Illegal LS opcode
    in_valid = 1'b1;
    set_b(5'h03, 5'h09, 5'h0E, 5'h12);
    tick("bad_ls");
    chk("bad_ls_out_err", 32'(out_err), 32'd1);
    chk("bad_ls_control", 32'(control), 32'd0);
    chk("bad_ls_slot_lit", 32'(err_slot), 32'd3);
    in_valid = 1'b0;
    tick("bad_ls_drain");

    // Backpressure: hold bundle A for 3 cycles while B waits
    in_valid  = 1'b1;
    out_ready = 1'b0;
    set_b(5'h0B, 5'h00, 5'h0D, 5'h10);
    tick("bp_accept_a");
    set_b(5'h07, 5'h0C, 5'h0C, 5'h11);
    tick("bp_hold1");
    tick("bp_hold2");
    tick("bp_hold3");
    out_ready = 1'b1;
    tick("bp_release");
    in_valid = 1'b0;
    tick("bp_drain");

    // Clear, then five illegal bundles to saturate the 2-bit counter
    err_clr = 1'b1;
    tick("clr");
    err_clr  = 1'b0;
    in_valid = 1'b1;
    set_b(5'h00, 5'h1F, 5'h0C, 5'h0C);
    tick("sat1");
    set_b(5'h0D, 5'h00, 5'h0C, 5'h0C);
    tick("sat2");
    set_b(5'h00, 5'h00, 5'h00, 5'h0C);
    tick("sat3");
    set_b(5'h00, 5'h00, 5'h0C, 5'h13);
    tick("sat4");
    set_b(5'h1E, 5'h1E, 5'h1E, 5'h1E);
    tick("sat5");
    chk("sat_cnt_lit", 32'(err_cnt), 32'd3);
    chk("sat_slot_lit", 32'(err_slot), 32'd1);

    // Clear coincident with an illegal multiply opcode
    err_clr = 1'b1;
    set_b(5'h01, 5'h02, 5'h0F, 5'h0C);
    tick("clr_vs_err");
    err_clr = 1'b0;
    chk("clr_vs_err_slot_lit", 32'(err_slot), 32'd2);
    chk("clr_vs_err_cnt_lit", 32'(err_cnt), 32'd1);

    // Flush while holding, with an illegal bundle presented
    out_ready = 1'b0;
    set_b(5'h05, 5'h06, 5'h0D, 5'h10);
    tick("flush_load");
    flush = 1'b1;
    set_b(5'h1F, 5'h00, 5'h0C, 5'h0C);
    tick("flush");
    flush = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick("flush_after");

    // Mixed random traffic
    for (int i = 0; i < 24; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 3) != 0);
      set_b(5'($urandom_range(0, 13)), 5'($urandom_range(0, 12)),
            5'($urandom_range(12, 14)), (i % 3 == 0) ? 5'h10 : 5'h11);
      tick("rand");
    end

    // Reset mid-transfer drops the held bundle asynchronously
    in_valid  = 1'b1;
    out_ready = 1'b0;
    set_b(5'h08, 5'h00, 5'h1F, 5'h0C);
    tick("pre_rst");
    #2 rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    set_b(5'h0A, 5'h04, 5'h0D, 5'h10);
    tick("post_rst");
    in_valid = 1'b0;
    tick("post_rst_drain");
    tick("idle");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
